game_ctrl: RTL and testbench
============================

# game_ctrl

Sequencing controller for the memory game's number memory (10 slots × 10-bit patterns). It clears the memory and writes a fresh set of patterns while flashing each one on the LEDs. It then accepts switch guesses, uses the memory's `exist` flag to score hits and pulse deletes, and declares win or lose. It sits between the board I/O (switches, key, LEDs) and the number memory write/delete ports.

## Interface
- `SHOW_TICKS`, default 50_000_000: cycles each pattern stays on the LEDs during SHOW.
- `INPUT_TICKS`, default 500_000_000: cycles allowed between guesses before timeout.
- `clk`, in, 1: system clock.
- `clrn`, in, 1: reset, asynchronous, active-low.
- `start_n`, in, 1: raw start button, active-low, asynchronous to `clk`.
- `key_n`, in, 1: raw guess button, active-low, asynchronous to `clk`.
- `sw`, in, 10: user guess, also routed to the memory compare input.
- `exist`, in, 1: memory flag; `sw` is nonzero and matches a stored slot.
- `we`, out, 1: memory write enable.
- `wn`, out, 4: memory write slot, 0..9.
- `d`, out, 10: memory write data.
- `del_n`, out, 1: memory delete strobe, active-low. Drives the memory `input_key`.
- `led`, out, 10: display.
- `level`, out, 4: patterns in the current round, 1..10.
- `hits`, out, 4: correct guesses this round.
- `lives`, out, 2: remaining misses allowed.
- `win`, out, 1: round-complete flag.
- `lose`, out, 1: game-over flag.

## Operation
- **Reset values** (all registered): `we`=0, `wn`=0, `d`=0, `del_n`=1, `led`=0, `level`=1, `hits`=0, `lives`=3, `win`=0, `lose`=0, state=IDLE, LFSR=10'h001.
- **IDLE:** `led`=0. A start press goes to CLEAR.
- **CLEAR:** 10 cycles with `we`=1 and `wn`=0..9, `d`=0. Then `hits`=0, slot counter k=0, go to GEN.
- **GEN:** one cycle with `we`=1, `wn`=k, `d`={lfsr[5:0], k+1}.
  - The low nibble guarantees a nonzero value, unique per slot.
  - `led`=`d`. Advance the LFSR. Go to SHOW.
- **SHOW:** `we`=0 and `led` holds the pattern for SHOW_TICKS cycles.
  - Then k+1: go to GEN if k+1<`level`, else go to INPUT.
- **INPUT:** `led`=`sw`, timeout counter running.
  - **Hit:** on a guess press with `exist`=1, `hits`+1, `del_n` low for exactly one cycle, timeout counter reset.
  - **Miss:** on a guess press with `exist`=0, `lives`−1, no delete, timeout counter reset.
  - When `hits` reaches `level`, go to WIN. When `lives` reaches 0, go to LOSE.
  - Timeout (counter = INPUT_TICKS−1) goes to LOSE.
- **WIN:** `win`=1, `led`=10'h3FF.
  - A start press sets `level`=min(`level`+1, 10), clears `win`, goes to CLEAR.
- **LOSE:** `lose`=1, `led`=10'h155.
  - A start press sets `level`=1, `lives`=3, clears `lose`, goes to CLEAR.
- **LFSR:** 10-bit maximal, taps x^10+x^7+1. Free-runs every cycle in all states. Never loads zero.
- **Priority:** a press in any state other than IDLE/INPUT/WIN/LOSE is ignored. Start presses in INPUT are ignored.
- **Repeat hits:** a guess of an already-deleted pattern reads `exist`=0 and scores a miss.
- **Level 10:** a win at level 10 keeps `level`=10.

## Timing
- **Button conditioning:** each button has a 2-flop synchronizer and a falling-edge detect. A one-cycle press pulse is raised 3 cycles after the pin falls. Holding the button produces one pulse only.
- **Press cycle:** `exist` is sampled combinationally in the press-pulse cycle P.
  - `del_n` is low in cycle P+1; the memory deletes at the end of P+1.
  - `hits`/`lives` update at the end of P.
- **WIN/LOSE entry:** entered the cycle after the terminal `hits`/`lives` update. The `del_n` pulse still completes.
- **Write-path timing:**
  - CLEAR+GEN writes are single-cycle; `we`/`wn`/`d` are registered and stable for the full cycle.
  - Round start (start pulse to first SHOW cycle) takes 12 cycles: 10 for CLEAR, 1 for GEN, plus the state transition.
- **Reset mid-operation:** asynchronous return to the reset values, including `del_n`=1 and `we`=0 immediately. An in-flight write or delete is abandoned.

## Structure
- Package `game_pkg`: state enum (IDLE, CLEAR, GEN, SHOW, INPUT, WIN, LOSE), `N_SLOTS`=10, `LIVES_INIT`=3, `LED_WIN`=10'h3FF, `LED_LOSE`=10'h155, `LFSR_SEED`=10'h001.
- Sub-module `key_sync`: synchronizer plus falling-edge detect. Instantiated twice, for start and key.
- Top level: FSM, slot/tick/timeout counters, LFSR, output registers.

## Test plan
- **Level 1 round:** SHOW_TICKS=4, start press. Expect 10 CLEAR writes, then GEN `we`=1, `wn`=0, `d`={lfsr[5:0],4'd1}, and `led`=`d` for 4 cycles. Then `sw`=`d`, `exist`=1, key press: `del_n` low one cycle, `hits`=1, `win`=1, `led`=10'h3FF.
- **Miss to lose:** at level 3, three presses with `exist`=0. Expect `lives` 2,1,0, then `lose`=1, `led`=10'h155, `del_n` never low.
- **Timeout:** INPUT_TICKS=20, no press. Expect LOSE on cycle 20 of INPUT.
- **Held key:** hold `key_n` low 100 cycles. Expect exactly one press processed, one `del_n` pulse.
- **Level cap:** win at levels 1..10 in succession. Expect 10 GEN writes at level 10 with `wn` 0..9 and distinct `d` low nibbles 1..10. After a further win, `level` stays 10.
- **Mid-operation reset:** assert `clrn` during CLEAR (at `wn`=5) and during a `del_n` pulse. Expect all outputs at reset values within the same cycle, state IDLE, `level`=1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types, constants and pattern helpers for the memory-game sequencing controller.
package game_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, GEN, SHOW, INPUT, WIN, LOSE} state_t;

  localparam int unsigned N_SLOTS    = 10;
  localparam int unsigned SLOT_W     = 4;
  localparam int unsigned PAT_W      = 10;
  localparam int unsigned LIVES_INIT = 3;

  localparam logic [PAT_W-1:0] LED_WIN   = 10'h3FF;
  localparam logic [PAT_W-1:0] LED_LOSE  = 10'h155;
  localparam logic [PAT_W-1:0] LFSR_SEED = 10'h001;

  // x^10 + x^7 + 1, shift-left Fibonacci form; never reaches zero from a nonzero seed
  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  // Low nibble is slot+1, so every pattern is nonzero and unique per slot
  function automatic logic [PAT_W-1:0] pattern(input logic [5:0] r, input logic [SLOT_W-1:0] slot);
    return {r, slot + SLOT_W'(1)};
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Number-memory write/delete port as seen by the sequencing controller.
interface game_ctrl_if;
  import game_pkg::*;

  logic              we;
  logic [SLOT_W-1:0] wn;
  logic [PAT_W-1:0]  d;
  logic              del_n;
  logic              exist;

  modport master (output we, output wn, output d, output del_n, input exist);
  modport slave  (input we, input wn, input d, input del_n, output exist);
endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer with registered falling-edge detect: one pulse per press.
module key_sync (
  input  logic clk,
  input  logic clrn,
  input  logic btn_n,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s3    <= 1'b1;
      pulse <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      s3    <= s2;
      pulse <= s3 & ~s2;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Memory-game sequencer: clears and fills the number memory, shows patterns,
// scores guesses via the memory's exist flag and declares win or lose.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SHOW_TICKS  = 50_000_000,
  parameter int unsigned INPUT_TICKS = 500_000_000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start_n,
  input  logic              key_n,
  input  logic [PAT_W-1:0]  sw,
  game_ctrl_if.master       mem,
  output logic [PAT_W-1:0]  led,
  output logic [SLOT_W-1:0] level,
  output logic [SLOT_W-1:0] hits,
  output logic [1:0]        lives,
  output logic              win,
  output logic              lose
);

  localparam int unsigned TICK_W = 32;

  state_t            state;
  logic [SLOT_W-1:0] k;
  logic [SLOT_W-1:0] k_nxt_c;
  logic [TICK_W-1:0] tick;
  logic [PAT_W-1:0]  lfsr;
  logic              start_p;
  logic              key_p;
  logic              go_clear_c;

  key_sync u_start_sync (.clk(clk), .clrn(clrn), .btn_n(start_n), .pulse(start_p));
  key_sync u_key_sync   (.clk(clk), .clrn(clrn), .btn_n(key_n),   .pulse(key_p));

  assign k_nxt_c    = k + SLOT_W'(1);
  assign go_clear_c = start_p && (state == IDLE || state == WIN || state == LOSE);

  // Outputs are loaded on the edge entering a state so they line up with it
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      k         <= '0;
      tick      <= '0;
      lfsr      <= LFSR_SEED;
      mem.we    <= 1'b0;
      mem.wn    <= '0;
      mem.d     <= '0;
      mem.del_n <= 1'b1;
      led       <= '0;
      level     <= SLOT_W'(1);
      hits      <= '0;
      lives     <= 2'(LIVES_INIT);
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      lfsr      <= lfsr_next(lfsr);
      mem.we    <= 1'b0;
      mem.del_n <= 1'b1;

      if (go_clear_c) begin
        state  <= CLEAR;
        k      <= SLOT_W'(1);
        mem.we <= 1'b1;
        mem.wn <= '0;
        mem.d  <= '0;
        led    <= '0;
        win    <= 1'b0;
        lose   <= 1'b0;
        if (state == WIN && level != SLOT_W'(N_SLOTS)) level <= level + SLOT_W'(1);
        if (state == LOSE) begin
          level <= SLOT_W'(1);
          lives <= 2'(LIVES_INIT);
        end
      end else begin
        case (state)
          IDLE: led <= '0;

          CLEAR: begin
            mem.we <= 1'b1;
            if (k == SLOT_W'(N_SLOTS)) begin
              state  <= GEN;
              k      <= '0;
              hits   <= '0;
              mem.wn <= '0;
              mem.d  <= pattern(lfsr[5:0], '0);
              led    <= pattern(lfsr[5:0], '0);
            end else begin
              mem.wn <= k;
              mem.d  <= '0;
              k      <= k_nxt_c;
            end
          end

          GEN: begin
            tick  <= '0;
            state <= SHOW;
          end

          SHOW: begin
            if (tick == TICK_W'(SHOW_TICKS - 1)) begin
              tick <= '0;
              if (k_nxt_c < level) begin
                state  <= GEN;
                k      <= k_nxt_c;
                mem.we <= 1'b1;
                mem.wn <= k_nxt_c;
                mem.d  <= pattern(lfsr[5:0], k_nxt_c);
                led    <= pattern(lfsr[5:0], k_nxt_c);
              end else begin
                state <= INPUT;
                led   <= sw;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          INPUT: begin
            led <= sw;
            // Terminal checks run the cycle after the score update
            if (hits == level) begin
              state <= WIN;
              win   <= 1'b1;
              led   <= LED_WIN;
            end else if (lives == 2'd0) begin
              state <= LOSE;
              lose  <= 1'b1;
              led   <= LED_LOSE;
            end else if (key_p) begin
              tick <= '0;
              if (mem.exist) begin
                hits      <= hits + SLOT_W'(1);
                mem.del_n <= 1'b0;
              end else begin
                lives <= lives - 2'd1;
              end
            end else if (tick == TICK_W'(INPUT_TICKS - 1)) begin
              state <= LOSE;
              lose  <= 1'b1;
              led   <= LED_LOSE;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          WIN, LOSE: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: round sequencing, scoring, timeout, level cap and async reset.
module tb_game_ctrl;

  localparam int unsigned SHOW_T  = 4;
  localparam int unsigned INPUT_T = 20;

  logic       clk, clrn, start_n, key_n;
  logic [9:0] sw, led;
  logic [3:0] level, hits;
  logic [1:0] lives;
  logic       win, lose;

  int vectors     = 0;
  int miscompares = 0;
  int del_lows    = 0;
  int base;

  logic [9:0] m_lfsr, m_prev;
  logic [9:0] pat [10];

  game_ctrl_if mem ();

  game_ctrl #(.SHOW_TICKS(SHOW_T), .INPUT_TICKS(INPUT_T)) dut (
    .clk(clk), .clrn(clrn), .start_n(start_n), .key_n(key_n), .sw(sw), .mem(mem),
    .led(led), .level(level), .hits(hits), .lives(lives), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference x^10+x^7+1 sequence; m_prev is the value a write latched on the last edge
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_lfsr <= 10'h001;
      m_prev <= 10'h001;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
  end

  always @(negedge clk) if (clrn === 1'b1 && mem.del_n === 1'b0) del_lows++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"},    32'(mem.we), 0);
    chk({tag, "_wn"},    32'(mem.wn), 0);
    chk({tag, "_d"},     32'(mem.d), 0);
    chk({tag, "_del_n"}, 32'(mem.del_n), 1);
    chk({tag, "_led"},   32'(led), 0);
    chk({tag, "_level"}, 32'(level), 1);
    chk({tag, "_hits"},  32'(hits), 0);
    chk({tag, "_lives"}, 32'(lives), 3);
    chk({tag, "_win"},   32'(win), 0);
    chk({tag, "_lose"},  32'(lose), 0);
  endtask

  // Start press from IDLE/WIN/LOSE; returns on the first INPUT cycle
  task automatic start_round(input int lvl, input bit full);
    logic [9:0] e;
    start_n = 1'b0;
    step(4);
    start_n = 1'b1;
    chk("clear_first_we", 32'(mem.we), 1);
    chk("round_level",    32'(level), 32'(lvl));
    chk("round_win_clr",  32'(win), 0);
    chk("round_lose_clr", 32'(lose), 0);
    for (int j = 0; j < 10; j++) begin
      if (full) begin
        chk("clear_we", 32'(mem.we), 1);
        chk("clear_wn", 32'(mem.wn), 32'(j));
        chk("clear_d",  32'(mem.d), 0);
      end
      step(1);
    end
    if (full) chk("gen_hits_zero", 32'(hits), 0);
    for (int j = 0; j < lvl; j++) begin
      e = {m_prev[5:0], 4'(j + 1)};
      pat[j] = e;
      chk("gen_we", 32'(mem.we), 1);
      chk("gen_wn", 32'(mem.wn), 32'(j));
      chk("gen_d",  32'(mem.d), 32'(e));
      if (full) begin
        chk("gen_nibble", 32'(mem.d[3:0]), 32'(j + 1));
        chk("gen_led",    32'(led), 32'(e));
      end
      step(1);
      if (full) begin
        chk("show_we",  32'(mem.we), 0);
        chk("show_led", 32'(led), 32'(e));
      end
      step(3);
      if (full) chk("show_led_last", 32'(led), 32'(e));
      step(1);
    end
  endtask

  // Guess every stored pattern with exist high; ends in WIN
  task automatic guess_hits(input int lvl, input bit full);
    for (int j = 0; j < lvl; j++) begin
      sw        = pat[j];
      mem.exist = 1'b1;
      key_n     = 1'b0;
      step(3);
      if (full) chk("input_led_sw", 32'(led), 32'(pat[j]));
      chk("hit_del_before", 32'(mem.del_n), 1);
      step(1);
      chk("hit_del_low", 32'(mem.del_n), 0);
      chk("hit_count",   32'(hits), 32'(j + 1));
      key_n     = 1'b1;
      mem.exist = 1'b0;
      step(1);
      chk("hit_del_one_cycle", 32'(mem.del_n), 1);
      step(2);
    end
    chk("win_flag", 32'(win), 1);
    chk("win_led",  32'(led), 32'h3FF);
  endtask

  initial begin
    clrn      = 1'b0;
    start_n   = 1'b1;
    key_n     = 1'b1;
    sw        = '0;
    mem.exist = 1'b0;
    step(2);
    check_reset("reset");
    clrn = 1'b1;
    step(2);

    // Level 1 with a key held for 100 cycles
    sw = 10'h2C3;
    start_round(1, 1);
    chk("input_led_entry", 32'(led), 32'h2C3);
    sw        = pat[0];
    mem.exist = 1'b1;
    key_n     = 1'b0;
    base      = del_lows;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (i == 3) chk("held_hits_before", 32'(hits), 0);
      if (i == 4) begin
        chk("held_hits_after", 32'(hits), 1);
        chk("held_del_low",    32'(mem.del_n), 0);
      end
      if (i == 5) begin
        chk("held_win_entry", 32'(win), 1);
        chk("held_win_led",   32'(led), 32'h3FF);
        chk("held_del_high",  32'(mem.del_n), 1);
      end
    end
    key_n     = 1'b0;
    mem.exist = 1'b0;
    key_n     = 1'b1;
    step(3);
    chk("held_del_pulses", 32'(del_lows - base), 1);

    // Climb to level 10, full write checks at the top level
    for (int lvl = 2; lvl <= 10; lvl++) begin
      start_round(lvl, lvl == 10);
      guess_hits(lvl, lvl == 10);
    end

    // Level stays capped, then idle in INPUT until timeout
    start_round(10, 0);
    sw = '0;
    step(19);
    chk("timeout_not_yet", 32'(lose), 0);
    step(1);
    chk("timeout_lose", 32'(lose), 1);
    chk("timeout_led",  32'(led), 32'h155);

    // Restart from LOSE, climb to level 3, then miss three times
    start_round(1, 0);
    chk("lose_restart_lives", 32'(lives), 3);
    guess_hits(1, 0);
    start_round(2, 0);
    guess_hits(2, 0);
    start_round(3, 0);
    base      = del_lows;
    sw        = 10'h2AA;
    mem.exist = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      key_n = 1'b0;
      step(4);
      chk("miss_lives",   32'(lives), 32'(3 - m));
      chk("miss_no_lose", 32'(lose), 0);
      key_n = 1'b1;
      step(3);
    end
    chk("miss_lose",      32'(lose), 1);
    chk("miss_lose_led",  32'(led), 32'h155);
    chk("miss_no_delete", 32'(del_lows - base), 0);

    // Reset in the middle of CLEAR at level 2
    start_round(1, 0);
    guess_hits(1, 0);
    start_n = 1'b0;
    step(4);
    start_n = 1'b1;
    step(5);
    chk("midclr_wn",    32'(mem.wn), 5);
    chk("midclr_level", 32'(level), 2);
    clrn = 1'b0;
    #1;
    check_reset("midclr");
    step(1);
    clrn = 1'b1;
    step(2);

    // Reset during the delete strobe
    start_round(1, 1);
    sw        = pat[0];
    mem.exist = 1'b1;
    key_n     = 1'b0;
    step(4);
    chk("middel_del_low", 32'(mem.del_n), 0);
    chk("middel_hits",    32'(hits), 1);
    clrn = 1'b0;
    #1;
    check_reset("middel");
    key_n     = 1'b1;
    mem.exist = 1'b0;
    step(2);
    clrn = 1'b1;
    step(2);
    start_round(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
